// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared helpers and defaults for the parametrised synchronous FIFO.
//   - fifo_addr_w / fifo_cnt_w : pointer and occupancy widths derived from DEPTH
//   - fifo_is_pow2             : DEPTH legality check used at elaboration
//   - FIFO_DEF_*               : default width/depth/threshold constants
// No ports (package).
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_DEF_WIDTH     = 8;
    localparam int FIFO_DEF_DEPTH     = 16;
    localparam int FIFO_DEF_AE_THRESH = 2;
    // Default almost-full threshold sits this many entries below DEPTH.
    localparam int FIFO_AF_MARGIN     = 2;

    // Pointer width; a 1-entry array would still need one address bit.
    function automatic int fifo_addr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Occupancy needs one extra bit so that the value DEPTH is representable.
    function automatic int fifo_cnt_w(input int depth);
        return fifo_addr_w(depth) + 1;
    endfunction

    // Pointers wrap by natural overflow, which is only correct for 2^n depths.
    function automatic bit fifo_is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

    function automatic int fifo_def_af(input int depth);
        return depth - FIFO_AF_MARGIN;
    endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// -----------------------------------------------------------------------------
// fifo_mem_dp
// Simple dual-port storage array: one synchronous write port, one
// asynchronous read port. Contents are not reset.
// Ports:
//   clk      in   write clock
//   wr_en    in   write strobe
//   wr_addr  in   write address (ADDR_W)
//   wr_data  in   write data (DATA_WIDTH)
//   rd_addr  in   read address (ADDR_W)
//   rd_data  out  combinational read data (DATA_WIDTH)
// -----------------------------------------------------------------------------
module fifo_mem_dp
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DEF_WIDTH,
    parameter int DEPTH      = FIFO_DEF_DEPTH,
    parameter int ADDR_W     = fifo_addr_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/fifo_sync_param.sv
// -----------------------------------------------------------------------------
// fifo_sync_param
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and defined push/pop collision
// behaviour. Build option: define FIFO_SYNC_PARAM_FWFT_EN for first-word
// fall-through reads; otherwise data_out is registered and updates one cycle
// after an accepted pop.
// Ports:
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   push          in   write request (data_in sampled on the same edge)
//   pop           in   read request
//   data_in       in   write data (DATA_WIDTH)
//   clr_err       in   synchronous clear of overflow/underflow
//   data_out      out  read data (DATA_WIDTH)
//   empty         out  occupancy == 0
//   full          out  occupancy == DEPTH
//   almost_empty  out  occupancy <= AE_THRESH
//   almost_full   out  occupancy >= AF_THRESH
//   fifo_counter  out  occupancy (CNT_W)
//   overflow      out  sticky: a push was rejected
//   underflow     out  sticky: a pop was rejected
// -----------------------------------------------------------------------------
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DEF_WIDTH,
    parameter int DEPTH      = FIFO_DEF_DEPTH,
    parameter int AF_THRESH  = fifo_def_af(DEPTH),
    parameter int AE_THRESH  = FIFO_DEF_AE_THRESH,
    localparam int CNT_W     = fifo_cnt_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [CNT_W-1:0]      fifo_counter,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int               ADDR_W  = fifo_addr_w(DEPTH);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_AF    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] C_AE    = CNT_W'(AE_THRESH);
    localparam logic             RST_AF  = 1'(AF_THRESH == 0);

    generate
        if (!fifo_is_pow2(DEPTH)) begin : g_depth_chk
            $error("fifo_sync_param: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [ADDR_W-1:0]     r_wr_ptr;
    logic [ADDR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_almost_empty;
    logic                  r_almost_full;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_pop_ok;
    logic                  w_push_ok;
    logic [CNT_W-1:0]      w_count_next;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // A full FIFO still takes a push when the head leaves on the same edge.
    assign w_pop_ok  = pop & ~r_empty;
    assign w_push_ok = push & (~r_full | w_pop_ok);

    always_comb begin
        w_count_next = r_count;
        if (w_push_ok && !w_pop_ok) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (w_pop_ok && !w_push_ok) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    fifo_mem_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (w_push_ok),
        .wr_addr (r_wr_ptr),
        .wr_data (data_in),
        .rd_addr (r_rd_ptr),
        .rd_data (w_rd_data)
    );

    // Flags are derived from the next occupancy so they change on the same
    // edge as fifo_counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_empty <= 1'b1;
            r_almost_full  <= RST_AF;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            r_count        <= w_count_next;
            r_empty        <= (w_count_next == '0);
            r_full         <= (w_count_next == C_DEPTH);
            r_almost_empty <= (w_count_next <= C_AE);
            r_almost_full  <= (w_count_next >= C_AF);
            // A new error on the same edge as clr_err keeps the flag set.
            r_overflow     <= (push & ~w_push_ok) | (r_overflow & ~clr_err);
            r_underflow    <= (pop & ~w_pop_ok) | (r_underflow & ~clr_err);
        end
    end

`ifdef FIFO_SYNC_PARAM_FWFT_EN
    // Head word is presented as soon as it exists; zero while empty.
    assign data_out = r_empty ? '0 : w_rd_data;
`else
    logic [DATA_WIDTH-1:0] r_data_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out <= '0;
        end else if (w_pop_ok) begin
            r_data_out <= w_rd_data;
        end
    end

    assign data_out = r_data_out;
`endif

    assign empty        = r_empty;
    assign full         = r_full;
    assign almost_empty = r_almost_empty;
    assign almost_full  = r_almost_full;
    assign fifo_counter = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync_param.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_param
// Drives two FIFO instances: A (DEPTH=4, default thresholds 2/2) and
// B (DEPTH=16, AF=14, AE=2). A list-based reference model tracks contents,
// occupancy, read data and sticky errors; a negedge process compares both
// instances against it every cycle, and directed steps add literal checks.
// -----------------------------------------------------------------------------
module tb_fifo_sync_param;

`ifdef FIFO_SYNC_PARAM_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;

    logic       push_a, pop_a, clr_a;
    logic [7:0] din_a, dout_a;
    logic       emp_a, full_a, ae_a, af_a, ov_a, un_a;
    logic [2:0] cnt_a;

    logic       push_b, pop_b, clr_b;
    logic [7:0] din_b, dout_b;
    logic       emp_b, full_b, ae_b, af_b, ov_b, un_b;
    logic [4:0] cnt_b;

    fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .push(push_a), .pop(pop_a), .data_in(din_a),
        .clr_err(clr_a), .data_out(dout_a), .empty(emp_a), .full(full_a),
        .almost_empty(ae_a), .almost_full(af_a), .fifo_counter(cnt_a),
        .overflow(ov_a), .underflow(un_a)
    );

    fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .push(push_b), .pop(pop_b), .data_in(din_b),
        .clr_err(clr_b), .data_out(dout_b), .empty(emp_b), .full(full_b),
        .almost_empty(ae_b), .almost_full(af_b), .fifo_counter(cnt_b),
        .overflow(ov_b), .underflow(un_b)
    );

    // ---------------- reference model ----------------
    int         m_depth [2] = '{4, 16};
    int         m_af    [2] = '{2, 14};
    int         m_ae    [2] = '{2, 2};
    logic [7:0] m_list  [2][16];
    int         m_cnt   [2];
    logic [7:0] m_dout  [2];
    bit         m_ov    [2];
    bit         m_un    [2];

    int tests  = 0;
    int failed = 0;
    bit cmp_en = 1'b0;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i]  = 0;
            m_dout[i] = 8'h00;
            m_ov[i]   = 1'b0;
            m_un[i]   = 1'b0;
        end
    endtask

    task automatic model_step(input int i, input bit ps, input bit pp,
                              input logic [7:0] d, input bit clr);
        bit pop_ok;
        bit push_ok;
        pop_ok  = pp && (m_cnt[i] > 0);
        push_ok = ps && ((m_cnt[i] < m_depth[i]) || pop_ok);
        if (pop_ok) begin
            m_dout[i] = m_list[i][0];
            for (int k = 0; k < 15; k++) m_list[i][k] = m_list[i][k+1];
            m_cnt[i]--;
        end
        if (push_ok) begin
            m_list[i][m_cnt[i]] = d;
            m_cnt[i]++;
        end
        m_ov[i] = (ps && !push_ok) || (m_ov[i] && !clr);
        m_un[i] = (pp && !pop_ok) || (m_un[i] && !clr);
    endtask

    function automatic int exp_dout(input int i);
        if (FWFT) return (m_cnt[i] == 0) ? 0 : int'(m_list[i][0]);
        return int'(m_dout[i]);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input int i, input string tag, input int cnt, input int dout,
                            input bit emp, input bit fl, input bit ae, input bit af,
                            input bit ov, input bit un);
        check({tag, "_cnt"},   cnt,  m_cnt[i]);
        check({tag, "_dout"},  dout, exp_dout(i));
        check({tag, "_empty"}, int'(emp), int'(m_cnt[i] == 0));
        check({tag, "_full"},  int'(fl),  int'(m_cnt[i] == m_depth[i]));
        check({tag, "_ae"},    int'(ae),  int'(m_cnt[i] <= m_ae[i]));
        check({tag, "_af"},    int'(af),  int'(m_cnt[i] >= m_af[i]));
        check({tag, "_ovf"},   int'(ov),  int'(m_ov[i]));
        check({tag, "_udf"},   int'(un),  int'(m_un[i]));
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp_inst(0, "cyc_a", int'(cnt_a), int'(dout_a), emp_a, full_a, ae_a, af_a, ov_a, un_a);
            cmp_inst(1, "cyc_b", int'(cnt_b), int'(dout_b), emp_b, full_b, ae_b, af_b, ov_b, un_b);
        end
    end

    // ---------------- stimulus helpers ----------------
    // Model advances on the same edge the DUT samples; returns 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            model_step(0, push_a, pop_a, din_a, clr_a);
            model_step(1, push_b, pop_b, din_b, clr_b);
        end
        #1;
    endtask

    task automatic op_a(input bit ps, input bit pp, input logic [7:0] d, input bit clr);
        push_a = ps; pop_a = pp; din_a = d; clr_a = clr;
        tick();
        push_a = 1'b0; pop_a = 1'b0; clr_a = 1'b0;
    endtask

    task automatic op_b(input bit ps, input bit pp, input logic [7:0] d, input bit clr);
        push_b = ps; pop_b = pp; din_b = d; clr_b = clr;
        tick();
        push_b = 1'b0; pop_b = 1'b0; clr_b = 1'b0;
    endtask

    int exp_std [4] = '{1, 2, 3, 165};
    int exp_fw  [4] = '{2, 3, 165, 0};

    initial begin
        rst_n  = 1'b1;
        push_a = 1'b0; pop_a = 1'b0; clr_a = 1'b0; din_a = 8'h00;
        push_b = 1'b0; pop_b = 1'b0; clr_b = 1'b0; din_b = 8'h00;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_cnt",   int'(cnt_a), 0);
        check("rst_empty", int'(emp_a), 1);
        check("rst_full",  int'(full_a), 0);
        check("rst_ae",    int'(ae_a), 1);
        check("rst_af",    int'(af_a), 0);
        check("rst_dout",  int'(dout_a), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cmp_en = 1'b1;

        // Fill, overflow, drain, underflow on A
        for (int k = 0; k < 4; k++) begin
            op_a(1'b1, 1'b0, 8'(k), 1'b0);
            check("fill_cnt", int'(cnt_a), k + 1);
        end
        check("fill_full", int'(full_a), 1);
        op_a(1'b1, 1'b0, 8'd4, 1'b0);
        check("ovf_set", int'(ov_a), 1);
        check("ovf_cnt", int'(cnt_a), 4);
        for (int k = 0; k < 4; k++) begin
            op_a(1'b0, 1'b1, 8'h00, 1'b0);
            check("drain_dout", int'(dout_a), FWFT ? ((k < 3) ? k + 1 : 0) : k);
        end
        check("drain_empty", int'(emp_a), 1);
        op_a(1'b0, 1'b1, 8'h00, 1'b0);
        check("udf_set", int'(un_a), 1);
        op_a(1'b0, 1'b0, 8'h00, 1'b1);
        check("clr_ovf", int'(ov_a), 0);
        check("clr_udf", int'(un_a), 0);

        // Push into full FIFO with simultaneous pop
        for (int k = 0; k < 4; k++) op_a(1'b1, 1'b0, 8'(k), 1'b0);
        op_a(1'b1, 1'b1, 8'hA5, 1'b0);
        check("fullpp_cnt", int'(cnt_a), 4);
        check("fullpp_ovf", int'(ov_a), 0);
        check("fullpp_dout", int'(dout_a), FWFT ? 1 : 0);
        for (int k = 0; k < 4; k++) begin
            op_a(1'b0, 1'b1, 8'h00, 1'b0);
            check("fullpp_drain", int'(dout_a), FWFT ? exp_fw[k] : exp_std[k]);
        end

        // Wrap-around streaming with one entry in flight
        op_a(1'b1, 1'b0, 8'd100, 1'b0);
        for (int k = 0; k < 20; k++) begin
            op_a(1'b1, 1'b1, 8'(101 + k), 1'b0);
            check("wrap_cnt", int'(cnt_a), 1);
            check("wrap_dout", int'(dout_a), FWFT ? 101 + k : 100 + k);
        end
        check("wrap_ovf", int'(ov_a), 0);
        check("wrap_udf", int'(un_a), 0);
        op_a(1'b0, 1'b1, 8'h00, 1'b0);
        check("wrap_empty", int'(emp_a), 1);

        // Thresholds and sticky error clearing on B
        for (int k = 0; k <= 16; k++) begin
            op_b(1'b1, 1'b0, 8'(k), 1'b0);
            check("thr_ae", int'(ae_b), (k + 1 <= 2) ? 1 : 0);
            check("thr_af", int'(af_b), (k + 1 >= 14) ? 1 : 0);
        end
        check("thr_cnt", int'(cnt_b), 16);
        check("thr_ovf", int'(ov_b), 1);
        op_b(1'b0, 1'b0, 8'h00, 1'b1);
        check("thr_clr", int'(ov_b), 0);
        op_b(1'b1, 1'b0, 8'd99, 1'b1);
        check("thr_setwins", int'(ov_b), 1);

        // Asynchronous reset mid-stream
        for (int k = 0; k < 3; k++) op_a(1'b1, 1'b0, 8'(7 + k), 1'b0);
        check("pre_rst_cnt", int'(cnt_a), 3);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_cnt",   int'(cnt_a), 0);
        check("arst_empty", int'(emp_a), 1);
        check("arst_dout",  int'(dout_a), 0);
        check("arst_ovf_b", int'(ov_b), 0);
        check("arst_cnt_b", int'(cnt_b), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        op_a(1'b1, 1'b0, 8'h55, 1'b0);
        check("post_push_dout", int'(dout_a), FWFT ? 85 : 0);
        op_a(1'b0, 1'b1, 8'h00, 1'b0);
        check("post_pop_dout", int'(dout_a), FWFT ? 0 : 85);

        // Fall-through ordering
        op_a(1'b1, 1'b0, 8'h11, 1'b0);
        check("ft_first", int'(dout_a), FWFT ? 17 : 85);
        op_a(1'b1, 1'b0, 8'h22, 1'b0);
        op_a(1'b0, 1'b1, 8'h00, 1'b0);
        check("ft_second", int'(dout_a), FWFT ? 34 : 17);
        op_a(1'b0, 1'b1, 8'h00, 1'b0);
        check("ft_empty", int'(emp_a), 1);
        check("ft_last", int'(dout_a), FWFT ? 0 : 34);

        repeat (2) tick();
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Parametrised synchronous FIFO, the next generation of the team's 8-bit FIFO block.
- Width and depth are parameters.
- Adds programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and defined simultaneous push/pop rules.
- Compile-time first-word-fall-through read mode.
- Buffers a data stream between a producer using push/data_in and a consumer using pop/data_out, all in one clock domain.

Parameters:
DATA_WIDTH, 8, width of data_in/data_out in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
AF_THRESH, DEPTH-2, almost_full asserted when fifo_counter >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserted when fifo_counter <= AE_THRESH (0..DEPTH-1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
push  input  1  write request; data_in sampled on the same edge
pop  input  1  read request
data_in  input  DATA_WIDTH  write data
clr_err  input  1  synchronous clear of the sticky error flags
data_out  output  DATA_WIDTH  read data
empty  output  1  fifo_counter == 0
full  output  1  fifo_counter == DEPTH
almost_empty  output  1  fifo_counter <= AE_THRESH
almost_full  output  1  fifo_counter >= AF_THRESH
fifo_counter  output  CNT_W  occupancy, CNT_W = $clog2(DEPTH)+1
overflow  output  1  sticky: a push was rejected
underflow  output  1  sticky: a pop was rejected

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect mid-operation):
  - Read/write pointers and fifo_counter go to 0; overflow and underflow go to 0; data_out goes to 0.
  - empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0 ? 1 : 0).
  - Memory contents are not reset. Release is synchronous to clk through the normal flop path.
- Pointers:
  - ADDR_W = $clog2(DEPTH) bits each; wrap naturally from DEPTH-1 to 0.
  - Occupancy is held in the fifo_counter register, not derived from the pointers.
- Acceptance rules, evaluated at the rising edge:
  - pop_ok = pop & !empty.
  - push_ok = push & (!full | pop_ok). Push into a full FIFO is accepted only when a pop is accepted in the same cycle.
  - push & !push_ok sets overflow. pop & !pop_ok sets underflow.
  - A rejected operation changes nothing else.
- Simultaneous push and pop:
  - Both accepted: fifo_counter unchanged; write to wr_ptr, read from rd_ptr.
  - When empty, the push is accepted and the pop is an underflow.
- Counter: +1 on push_ok only; -1 on pop_ok only; otherwise held. Never exceeds DEPTH and never goes below 0.
- Flags are registered outputs, updated in the same cycle as fifo_counter and consistent with its new value.
- Sticky errors:
  - Cleared when clr_err=1 at a clock edge.
  - If a new error event and clr_err occur in the same cycle, the set wins.
- Standard read mode (macro undefined):
  - data_out is registered. On pop_ok, data_out takes mem[rd_ptr] at that edge, so it is valid one cycle after pop is sampled.
  - Otherwise data_out holds its last value.
- Write: on push_ok, mem[wr_ptr] <= data_in; wr_ptr increments.
- No internal FSM beyond pointer/counter state. Latency from push to earliest pop_ok is 1 cycle (empty deasserts the edge after the first push).

Optional Feature:
Macro: FIFO_SYNC_PARAM_FWFT_EN
- Defined (first-word fall-through):
  - data_out = mem[rd_ptr] combinationally whenever empty=0, and 0 when empty=1.
  - pop acknowledges and consumes the head; the next word appears the cycle after pop_ok.
  - The acceptance, flag and error rules are unchanged.
  - The data_out reset value is 0 by construction, since the FIFO is empty.
- Undefined: the standard registered read mode described above.

Decomposition:
- Package fifo_pkg holds:
  - the CNT_W/ADDR_W derivation helper (clog2-based);
  - the default threshold constants;
  - the power-of-two check used by an elaboration-time assertion on DEPTH.
- Sub-module fifo_mem_dp: simple dual-port register array (one write port, one asynchronous read port, DATA_WIDTH x DEPTH, no reset).
- The top holds pointers, the counter, flags, error logic and the read-mode mux.

Test Plan:
- DEPTH=4, DATA_WIDTH=8, standard mode:
  - push data_in 0,1,2,3 on consecutive cycles -> fifo_counter 1,2,3,4; full=1 after the 4th.
  - push 4 -> overflow=1, counter stays 4.
  - pop 4 cycles -> data_out 0,1,2,3 (each one cycle after its pop), empty=1.
  - 5th pop -> underflow=1.
- Full FIFO (DEPTH=4 holding 0..3), push 8'hA5 with pop in the same cycle -> counter stays 4, overflow stays 0, data_out=0.
  - Drain -> 1,2,3,8'hA5.
- Wrap-around: DEPTH=4, 20 cycles of simultaneous push/pop of an incrementing value after one priming push -> output sequence is the input delayed by one entry, no error flags, counter constant at 1.
- Thresholds: DEPTH=16, AF_THRESH=14, AE_THRESH=2, fill 0..16 -> almost_empty deasserts at counter 3 and almost_full asserts at counter 14.
  - Then set overflow via an extra push, pulse clr_err -> overflow=0.
  - clr_err together with an overflowing push -> overflow remains 1.
- Async reset mid-stream: assert rst_n=0 between clock edges with counter=3 -> immediately counter=0, empty=1, data_out=0, flags cleared.
  - After release, push 8'h55 then pop -> data_out=8'h55.
- FWFT build: push 8'h11 -> data_out=8'h11 the cycle after, before any pop.
  - push 8'h22, then pop -> data_out=8'h22 next cycle.
  - pop again -> empty=1, data_out=0.
